// File: rtl/collision_detector.sv
// collision_detector: per-frame sprite overlap detector with player invulnerability window; COLLISION_HITCOUNT_EN adds a saturating hit_count output
module collision_detector #(
  parameter int MIN_OVERLAP   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int ID_W          = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            pixel_valid,
  input  logic            pbullet_px,
  input  logic            invader_px,
  input  logic [ID_W-1:0] invader_id,
  input  logic            ebullet_px,
  input  logic            player_px,
  output logic            invader_collision,
  output logic [ID_W-1:0] invader_hit_id,
  output logic            player_collision,
  output logic            invuln
`ifdef COLLISION_HITCOUNT_EN
  ,
  output logic [7:0]      hit_count
`endif
);
  typedef enum logic {SCAN, REPORT} state_e;
  localparam logic [3:0] MIN = 4'(MIN_OVERLAP);
  localparam logic [7:0] INV = 8'(INVULN_FRAMES);
  state_e          state_q, state_d;
  logic [3:0]      inv_run_q, inv_run_d, pl_run_q, pl_run_d;
  logic [ID_W-1:0] last_id_q, last_id_d, pend_id_q, pend_id_d, hit_id_q, hit_id_d;
  logic            inv_hit_q, inv_hit_d, pl_hit_q, pl_hit_d;
  logic            inv_col_q, inv_col_d, pl_col_q, pl_col_d;
  logic [7:0]      inv_cnt_q, inv_cnt_d;
  logic            inv_ov, pl_ov;
  assign inv_ov = pixel_valid & pbullet_px & invader_px;
  assign pl_ov  = pixel_valid & ebullet_px & player_px;
  // Scan accumulation, end-of-frame report and invulnerability countdown
  always_comb begin
    state_d   = state_q;
    inv_run_d = inv_run_q;
    pl_run_d  = pl_run_q;
    last_id_d = last_id_q;
    pend_id_d = pend_id_q;
    hit_id_d  = hit_id_q;
    inv_hit_d = inv_hit_q;
    pl_hit_d  = pl_hit_q;
    inv_col_d = 1'b0;
    pl_col_d  = 1'b0;
    if (state_q == REPORT) begin
      state_d   = SCAN;
      inv_run_d = 4'd0;
      pl_run_d  = 4'd0;
    end else if (frame_start) begin
      state_d   = REPORT;
      inv_col_d = inv_hit_q;
      pl_col_d  = pl_hit_q;
      hit_id_d  = inv_hit_q ? pend_id_q : hit_id_q;
      inv_hit_d = 1'b0;
      pl_hit_d  = 1'b0;
      inv_run_d = 4'd0;
      pl_run_d  = 4'd0;
    end else begin
      inv_run_d = !inv_ov ? 4'd0 :
                  (inv_run_q != 4'd0 && invader_id != last_id_q) ? 4'd1 :
                  (inv_run_q == MIN) ? MIN : inv_run_q + 4'd1;
      pl_run_d  = !pl_ov ? 4'd0 : (pl_run_q == MIN) ? MIN : pl_run_q + 4'd1;
      last_id_d = invader_id;
      if (inv_run_d == MIN && !inv_hit_q) begin
        inv_hit_d = 1'b1;
        pend_id_d = invader_id;
      end
      if (pl_run_d == MIN && inv_cnt_q == 8'd0) pl_hit_d = 1'b1;
    end
    inv_cnt_d = pl_col_q ? INV :
                (frame_start && inv_cnt_q != 8'd0) ? inv_cnt_q - 8'd1 : inv_cnt_q;
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SCAN;
      inv_run_q <= '0;
      pl_run_q  <= '0;
      last_id_q <= '0;
      pend_id_q <= '0;
      hit_id_q  <= '0;
      inv_hit_q <= 1'b0;
      pl_hit_q  <= 1'b0;
      inv_col_q <= 1'b0;
      pl_col_q  <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      inv_run_q <= inv_run_d;
      pl_run_q  <= pl_run_d;
      last_id_q <= last_id_d;
      pend_id_q <= pend_id_d;
      hit_id_q  <= hit_id_d;
      inv_hit_q <= inv_hit_d;
      pl_hit_q  <= pl_hit_d;
      inv_col_q <= inv_col_d;
      pl_col_q  <= pl_col_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end
  assign invader_collision = inv_col_q;
  assign player_collision  = pl_col_q;
  assign invader_hit_id    = hit_id_q;
  assign invuln            = inv_cnt_q != 8'd0;
`ifdef COLLISION_HITCOUNT_EN
  logic [7:0] hit_cnt_q;
  // Saturating count of reported invader hits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hit_cnt_q <= '0;
    else if (inv_col_q && hit_cnt_q != 8'hFF) hit_cnt_q <= hit_cnt_q + 8'd1;
  end
  assign hit_count = hit_cnt_q;
`endif
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: randomized and directed checks against a frame-level reference model
module tb_collision_detector;
  localparam int MIN = 3;
  localparam int INVF = 60;
  logic       clk = 1'b0, rst = 1'b0;
  logic       frame_start = 1'b0, pixel_valid = 1'b0, pbullet_px = 1'b0, invader_px = 1'b0;
  logic       ebullet_px = 1'b0, player_px = 1'b0;
  logic [5:0] invader_id = '0;
  logic       invader_collision, player_collision, invuln;
  logic [5:0] invader_hit_id;
  int tests = 0, fails = 0;
  typedef struct {bit v, pb, iv, eb, pl; logic [5:0] id;} px_t;
  px_t q[$];
  int prot = 0;
  logic [5:0] exp_id = '0;
`ifdef COLLISION_HITCOUNT_EN
  logic [7:0] hit_count;
  int exp_hc = 0;
`endif

  collision_detector #(.MIN_OVERLAP(MIN), .INVULN_FRAMES(INVF), .ID_W(6)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pbullet_px(pbullet_px), .invader_px(invader_px), .invader_id(invader_id),
    .ebullet_px(ebullet_px), .player_px(player_px),
    .invader_collision(invader_collision), .invader_hit_id(invader_hit_id),
    .player_collision(player_collision), .invuln(invuln)
`ifdef COLLISION_HITCOUNT_EN
    , .hit_count(hit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_in(bit v, bit pb, bit iv, bit eb, bit pl, logic [5:0] id);
    pixel_valid = v; pbullet_px = pb; invader_px = iv; ebullet_px = eb; player_px = pl; invader_id = id;
  endtask

  task automatic pix(bit v, bit pb, bit iv, bit eb, bit pl, logic [5:0] id);
    px_t p;
    p.v = v; p.pb = pb; p.iv = iv; p.eb = eb; p.pl = pl; p.id = id;
    q.push_back(p);
    set_in(v, pb, iv, eb, pl, id);
    @(posedge clk); #1;
  endtask

  // Frame-level model: first run of MIN same-id overlaps wins; player hit needs any MIN run and no protection
  task automatic model_frame(output bit ih, output logic [5:0] hid, output bit ph);
    int ir = 0, pr = 0;
    logic [5:0] last = '0;
    bit pfound = 0;
    ih = 0; hid = '0;
    foreach (q[i]) begin
      if (q[i].v && q[i].pb && q[i].iv) begin
        ir = (ir > 0 && q[i].id == last) ? ir + 1 : 1;
        last = q[i].id;
        if (ir >= MIN && !ih) begin ih = 1; hid = q[i].id; end
      end else ir = 0;
      if (q[i].v && q[i].eb && q[i].pl) begin
        pr++;
        if (pr >= MIN) pfound = 1;
      end else pr = 0;
    end
    ph = pfound && prot == 0;
  endtask

  task automatic frame_end(string name);
    bit ih, ph;
    logic [5:0] hid;
    model_frame(ih, hid, ph);
    frame_start = 1'b1;
    set_in(1, 1, 1, 1, 1, 6'd63);
    @(posedge clk); #1;
    frame_start = 1'b0;
    set_in(0, 0, 0, 0, 0, '0);
    if (ih) exp_id = hid;
    tests++;
    if (invader_collision !== ih) begin fails++; $display("FAIL %s inv_pulse got=%b exp=%b", name, invader_collision, ih); end
    tests++;
    if (player_collision !== ph) begin fails++; $display("FAIL %s pl_pulse got=%b exp=%b", name, player_collision, ph); end
    tests++;
    if (invader_hit_id !== exp_id) begin fails++; $display("FAIL %s hit_id got=%0d exp=%0d", name, invader_hit_id, exp_id); end
    @(posedge clk); #1;
    tests++;
    if (invader_collision !== 1'b0 || player_collision !== 1'b0) begin
      fails++; $display("FAIL %s pulse_width inv=%b pl=%b exp=0", name, invader_collision, player_collision);
    end
    if (ph) prot = INVF; else if (prot > 0) prot--;
    tests++;
    if (invuln !== (prot != 0)) begin fails++; $display("FAIL %s invuln got=%b exp=%b", name, invuln, prot != 0); end
`ifdef COLLISION_HITCOUNT_EN
    if (ih && exp_hc < 255) exp_hc++;
    tests++;
    if (hit_count !== 8'(exp_hc)) begin fails++; $display("FAIL %s hit_count got=%0d exp=%0d", name, hit_count, exp_hc); end
`endif
    q.delete();
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (invader_collision !== 0 || player_collision !== 0 || invuln !== 0 || invader_hit_id !== 0) begin
      fails++; $display("FAIL reset outputs inv=%b pl=%b invuln=%b id=%0d exp=0", invader_collision, player_collision, invuln, invader_hit_id);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_invader_hit();
    for (int i = 0; i < 3; i++) pix(1, 1, 1, 0, 0, 6'd5);
    pix(1, 0, 0, 0, 0, 6'd0);
    frame_end("inv5");
  endtask

  task automatic test_short_overlap();
    for (int i = 0; i < 2; i++) pix(1, 1, 1, 1, 1, 6'd3);
    pix(0, 1, 1, 1, 1, 6'd3);
    frame_end("short");
    for (int i = 0; i < 4; i++) pix(1, 0, 0, 0, 0, 6'd0);
    frame_end("clean");
  endtask

  task automatic test_first_wins();
    for (int i = 0; i < 3; i++) pix(1, 1, 1, 0, 0, 6'd7);
    pix(1, 0, 1, 0, 0, 6'd7);
    for (int i = 0; i < 4; i++) pix(1, 1, 1, 0, 0, 6'd9);
    frame_end("first_wins");
  endtask

  task automatic test_both();
    for (int i = 0; i < 3; i++) pix(1, 1, 1, 1, 1, 6'd12);
    frame_end("both");
  endtask

  task automatic test_invuln();
    for (int i = 0; i < 3; i++) pix(1, 0, 0, 1, 1, 6'd0);
    frame_end("pl_hit");
    for (int f = 0; f < INVF + 1; f++) begin
      for (int i = 0; i < 3; i++) pix(1, 0, 0, 1, 1, 6'd0);
      frame_end($sformatf("invuln_f%0d", f + 1));
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) pix(1, 1, 1, 1, 1, 6'd4);
    rst = 1'b0;
    #1;
    tests++;
    if (invader_collision !== 0 || player_collision !== 0 || invuln !== 0 || invader_hit_id !== 0) begin
      fails++; $display("FAIL mid_reset outputs inv=%b pl=%b invuln=%b id=%0d exp=0", invader_collision, player_collision, invuln, invader_hit_id);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    prot = 0;
    exp_id = '0;
`ifdef COLLISION_HITCOUNT_EN
    exp_hc = 0;
`endif
    frame_end("after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++)
        pix($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 2)));
      frame_end($sformatf("rand_f%0d", f));
    end
  endtask

  initial begin
    test_reset();
    test_invader_hit();
    test_short_overlap();
    test_first_wins();
    test_both();
    test_invuln();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
